// File: rtl/io_arb_pkg.sv
// Shared types and constants for the board I/O arbiter: FSM states, register
// addresses and the per-access command payload.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    localparam logic [1:0] ADDR_LEDG = 2'd0;
    localparam logic [1:0] ADDR_HEX  = 2'd1;
    localparam logic [1:0] ADDR_SW   = 2'd2;
    localparam logic [1:0] ADDR_BTN  = 2'd3;

    localparam int unsigned LEDG_W = 10;
    localparam int unsigned HEX_W  = 16;
    localparam int unsigned SW_W   = 10;
    localparam int unsigned BTN_W  = 2;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
    } io_cmd_t;

endpackage

// File: rtl/io_arbiter_if.sv
// Per-core request/grant bus between the processor cores and io_arbiter.
// With IO_ARB_LOCK_EN defined the bus carries a per-core lock vector.
interface io_arbiter_if #(
    parameter int unsigned NCORES = 4,
    parameter int unsigned DW     = 16
);
    logic [NCORES-1:0]          req;
    logic [NCORES-1:0]          we;
    logic [NCORES-1:0][1:0]     addr;
    logic [NCORES-1:0][DW-1:0]  wdata;
    logic [NCORES-1:0]          gnt;
    logic [NCORES-1:0]          ack;
    logic [DW-1:0]              rdata;
`ifdef IO_ARB_LOCK_EN
    logic [NCORES-1:0]          lock;

    modport master (output req, we, addr, wdata, lock, input gnt, ack, rdata);
    modport slave  (input req, we, addr, wdata, lock, output gnt, ack, rdata);
`else
    modport master (output req, we, addr, wdata, input gnt, ack, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);
`endif
endinterface

// File: rtl/io_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module io_rr_picker #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_c
);
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter giving NCORES cores access to the board LEDs, hex display,
// switches and buttons. Optional macro IO_ARB_LOCK_EN enables locked back-to-back access.
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned NCORES = 4,
    parameter int unsigned DW     = 16
) (
    input  logic              CLOCK_50,
    input  logic              nReset,
    io_arbiter_if.slave       bus,
    input  logic [SW_W-1:0]   SW,
    input  logic [BTN_W-1:0]  Buttons,
    output logic [LEDG_W-1:0] LEDG,
    output logic [HEX_W-1:0]  hex_value
);
    localparam int unsigned PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    arb_state_e         state, state_nxt;
    logic [NCORES-1:0]  gnt_r, gnt_nxt, ack_r, ack_nxt, pick_c;
    logic [DW-1:0]      rdata_r, rdata_nxt, rd_c, wdata_c;
    logic [PW-1:0]      ptr, ptr_nxt, pick_idx, sel_idx;
    logic [LEDG_W-1:0]  ledg_nxt;
    logic [HEX_W-1:0]   hex_nxt;
    logic [SW_W-1:0]    sw_s1, sw_s2;
    logic [BTN_W-1:0]   btn_s1, btn_s2, btn_s3, pending, btn_rise_c;
    logic               btn_clr_c;
    io_cmd_t            cmd_c;

    io_rr_picker #(.N(NCORES)) u_picker (
        .req   (bus.req),
        .ptr   (ptr),
        .gnt_c (pick_c)
    );

    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_r;
    assign bus.rdata = rdata_r;

    // One-hot to index for the fresh pick and for the core currently granted
    always_comb begin
        pick_idx = '0;
        sel_idx  = '0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            if (pick_c[i]) pick_idx = PW'(i);
            if (gnt_r[i])  sel_idx  = PW'(i);
        end
    end

    assign cmd_c   = {bus.we[sel_idx], bus.addr[sel_idx]};
    assign wdata_c = bus.wdata[sel_idx];

    always_comb begin
        rd_c = '0;
        case (cmd_c.addr)
            ADDR_LEDG: rd_c = DW'(LEDG);
            ADDR_HEX:  rd_c = DW'(hex_value);
            ADDR_SW:   rd_c = DW'(sw_s2);
            default:   rd_c = DW'(pending);
        endcase
    end

    // Button edges are detected on the synchronised copy; a fresh edge beats a clearing read
    assign btn_rise_c = btn_s2 & ~btn_s3;

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            btn_s1  <= '0;
            btn_s2  <= '0;
            btn_s3  <= '0;
            pending <= '0;
        end else begin
            sw_s1   <= SW;
            sw_s2   <= sw_s1;
            btn_s1  <= Buttons;
            btn_s2  <= btn_s1;
            btn_s3  <= btn_s2;
            pending <= (btn_clr_c ? '0 : pending) | btn_rise_c;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            gnt_r     <= '0;
            ack_r     <= '0;
            rdata_r   <= '0;
            ptr       <= '0;
            LEDG      <= '0;
            hex_value <= '0;
        end else begin
            state     <= state_nxt;
            gnt_r     <= gnt_nxt;
            ack_r     <= ack_nxt;
            rdata_r   <= rdata_nxt;
            ptr       <= ptr_nxt;
            LEDG      <= ledg_nxt;
            hex_value <= hex_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bus.req) state_nxt = GRANT;
            GRANT:   state_nxt = ACK;
            ACK: begin
                state_nxt = IDLE;
`ifdef IO_ARB_LOCK_EN
                if (|(bus.lock & ack_r)) state_nxt = GRANT;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The access itself happens on the GRANT->ACK edge
    always_comb begin
        gnt_nxt   = '0;
        ack_nxt   = '0;
        rdata_nxt = '0;
        ptr_nxt   = ptr;
        ledg_nxt  = LEDG;
        hex_nxt   = hex_value;
        btn_clr_c = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    gnt_nxt = pick_c;
                    ptr_nxt = (pick_idx == PW'(NCORES - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            GRANT: begin
                ack_nxt   = gnt_r;
                rdata_nxt = rd_c;
                if (cmd_c.we) begin
                    if (cmd_c.addr == ADDR_LEDG)     ledg_nxt = wdata_c[LEDG_W-1:0];
                    else if (cmd_c.addr == ADDR_HEX) hex_nxt  = wdata_c[HEX_W-1:0];
                end else if (cmd_c.addr == ADDR_BTN) begin
                    btn_clr_c = 1'b1;
                end
            end
            ACK: begin
`ifdef IO_ARB_LOCK_EN
                if (|(bus.lock & ack_r)) gnt_nxt = ack_r;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter NCORES, default 4: number of processor cores sharing the board I/O.
REQ-002 Parameter DW, default 16: I/O data width.
REQ-003 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 nReset  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NCORES  per-core access request.
REQ-006 we  input  NCORES  per-core write enable, 1=write, 0=read.
REQ-007 addr  input  NCORES x 2  per-core register select: 0 LEDG, 1 HEX, 2 SW, 3 BTN.
REQ-008 wdata  input  NCORES x DW  per-core write data.
REQ-009 gnt  output  NCORES  one-hot grant.
REQ-010 ack  output  NCORES  one-hot, single-cycle access-complete strobe.
REQ-011 rdata  output  DW  shared read data, valid only in the ack cycle.
REQ-012 SW  input  10  board switches, asynchronous to CLOCK_50.
REQ-013 Buttons  input  2  board buttons, active-high (already inverted), asynchronous.
REQ-014 LEDG  output  10  LED register.
REQ-015 hex_value  output  16  value for the four seven-segment decoders.

Function
REQ-016 FSM states IDLE, GRANT, ACK; IDLE->GRANT when any req=1, GRANT->ACK unconditionally, ACK->IDLE.
REQ-017 Latency: req sampled in IDLE at cycle n -> gnt in cycle n+1 -> access performed and ack plus rdata in cycle n+2.
REQ-018 Arbitration round-robin: search starts at index last_granted+1 modulo NCORES; after reset search starts at core 0.
REQ-019 The requester holds req/we/addr/wdata stable until ack; req dropped during GRANT does not abort the access.
REQ-020 A req still high in the cycle after ack counts as a new request, arbitrated normally.
REQ-021 Write to addr 0 loads LEDG <= wdata[9:0]; write to addr 1 loads hex_value <= wdata[15:0].
REQ-022 Writes to addr 2 and 3 are ignored; ack is still issued.
REQ-023 Reads: addr 0 returns LEDG, addr 1 hex_value, addr 2 synchronized SW, addr 3 {pending[1:0]}; all zero-extended to DW.
REQ-024 SW and Buttons pass through a 2-flop synchronizer; each Buttons rising edge sets pending[i].
REQ-025 A read of addr 3 clears pending in the ack cycle; a new edge in that same cycle wins, so the bit stays set.
REQ-026 rdata = 0 and ack = 0 outside the ACK state.

Reset
REQ-027 nReset low forces state IDLE, gnt=0, ack=0, rdata=0, LEDG=0, hex_value=0, pending=0, synchronizers=0, RR pointer=core 0, immediately and mid-transaction.
REQ-028 A transaction interrupted by reset is dropped: no ack and no register update.

Configuration
REQ-029 Macro IO_ARB_LOCK_EN adds input lock (NCORES): lock high on the granted core in the ACK cycle sends ACK->GRANT for that same core, skipping arbitration.
REQ-030 Without IO_ARB_LOCK_EN the lock port does not exist and ACK always returns to IDLE.

Structure
REQ-031 Package io_arb_pkg holds the state enum and the address constants ADDR_LEDG, ADDR_HEX, ADDR_SW, ADDR_BTN.
REQ-032 Sub-module io_rr_picker: combinational round-robin one-hot picker (req vector, pointer -> one-hot grant).

Verification
REQ-033 Reset, core 1 writes addr 0 data 0x2A5 -> gnt[1] at +1, ack[1] at +2, LEDG=0x2A5.
REQ-034 Cores 0-3 request together, repeatedly -> grant order 0,1,2,3,0; each ack 3 cycles apart.
REQ-035 SW=0x155, wait 3 cycles, core 2 reads addr 2 -> rdata=0x0155 in the ack cycle.
REQ-036 Pulse Buttons[0], core 0 reads addr 3 -> rdata=0x0001; second read -> 0x0000; edge coinciding with the clearing read -> next read 0x0001.
REQ-037 nReset low during GRANT of a write to addr 1 -> no ack, hex_value=0, next request is granted to core 0 first.
REQ-038 With IO_ARB_LOCK_EN, core 3 holds lock over 3 writes while core 0 requests -> core 3 acked 3 times back-to-back, then core 0 granted.
